vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 19, framebuffer address width.
- DATA_W, 8, pixel colour-index width.
- FB_WORDS, 307200, framebuffer depth (640x480).
- FIFO_DEPTH, 4, CPU write-buffer entries.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, single system clock; all logic rises on it.
- reset, in, 1, asynchronous, active-high reset.
- vga_rd_req, in, 1, VGA controller pixel-fetch request.
- vga_rd_addr, in, ADDR_W, pixel address for the fetch.
- vga_rd_valid, out, 1, fetched pixel available.
- vga_rd_data, out, DATA_W, fetched pixel index.
- cpu_wr_valid, in, 1, processor write offered.
- cpu_wr_ready, out, 1, write buffer can accept.
- cpu_wr_addr, in, ADDR_W, processor write address.
- cpu_wr_data, in, DATA_W, processor write pixel.
- clr_start, in, 1, one-cycle pulse that starts a screen clear.
- clr_color, in, DATA_W, fill value for the clear.
- clr_busy, out, 1, clear in progress.
- mem_addr, out, ADDR_W, single-port RAM address.
- mem_we, out, 1, RAM write enable.
- mem_wdata, out, DATA_W, RAM write data.
- mem_rdata, in, DATA_W, RAM read data (synchronous, 1-cycle latency).

REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.

Function
REQ-004 The block SHALL grant exactly one RAM access per cycle, by fixed priority: VGA read, then FIFO drain, then clear engine.
REQ-005 mem_addr, mem_we and mem_wdata SHALL be combinational from the current-cycle grant; with no grant, mem_we=0 and mem_addr=0.
REQ-006 A vga_rd_req in cycle N SHALL drive mem_addr=vga_rd_addr and mem_we=0 in cycle N.
REQ-007 The response to a cycle-N read SHALL have vga_rd_valid=1 in cycle N+1, with vga_rd_data=mem_rdata in that cycle; vga_rd_data SHALL be 0 whenever vga_rd_valid=0.
REQ-008 VGA reads SHALL never be stalled; back-to-back requests SHALL yield back-to-back valids.
REQ-009 cpu_wr_ready SHALL equal "FIFO not full"; a write is accepted when cpu_wr_valid and cpu_wr_ready are both high.
REQ-010 Accepted writes SHALL drain in order; a write accepted in cycle N SHALL reach the RAM no earlier than cycle N+1 (no bypass).
REQ-011 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-012 When full, cpu_wr_ready SHALL be 0, and ready SHALL rise in the cycle after a pop.
REQ-013 The clear FSM states SHALL be IDLE and CLEAR. IDLE->CLEAR on clr_start, which latches clr_color and zeroes the 19-bit counter. In CLEAR, each granted cycle writes the latched colour to the counter address and increments the counter.
REQ-014 The clear FSM SHALL go CLEAR->IDLE in the cycle after the write to address FB_WORDS-1; the counter SHALL never exceed FB_WORDS-1.
REQ-015 clr_busy SHALL be 1 exactly while in CLEAR; clr_start while busy SHALL be ignored.
REQ-016 The clear engine SHALL have no forward-progress guarantee under continuous VGA or CPU traffic.
REQ-017 CPU writes during CLEAR SHALL still be performed. A CPU write to a not-yet-cleared address is later overwritten, and software SHALL wait for clr_busy=0.

Reset
REQ-018 On reset assertion, outputs SHALL immediately be: vga_rd_valid=0, vga_rd_data=0, clr_busy=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_wr_ready=1.
REQ-019 On reset assertion, the FIFO SHALL empty, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-020 Reset mid-clear SHALL abort the clear, and buffered CPU writes SHALL be discarded.
REQ-021 A read in flight across reset SHALL produce no vga_rd_valid.

Structure
REQ-022 Package vga_fb_pkg SHALL hold ADDR_W, DATA_W, FB_WORDS, FIFO_DEPTH and the clear-state enum.
REQ-023 The write buffer SHALL be a sub-module fb_wr_fifo (synchronous FIFO, count-based full/empty). Arbiter and clear FSM SHALL be in the top module.

Verification
REQ-024 Read: vga_rd_req=1 with addr 0x00010 in cycle 5, RAM holding 0x3C -> cycle 5 mem_addr=0x00010, mem_we=0; cycle 6 vga_rd_valid=1, vga_rd_data=0x3C.
REQ-025 CPU write under VGA load: push (0x00100, 0xAA) while vga_rd_req is held high for 10 cycles -> no mem_we during those cycles; mem_we=1 with addr 0x00100, data 0xAA in the first cycle vga_rd_req=0.
REQ-026 Full: 5 consecutive pushes with vga_rd_req held high -> pushes 1-4 accepted, cpu_wr_ready=0 on push 5. Release the read -> writes retire in order, and ready returns in the cycle after the first pop.
REQ-027 Clear: clr_start with clr_color=0x07 and idle traffic -> clr_busy high for exactly 307200 cycles; RAM address 0 and 307199 both read 0x07; a second clr_start mid-clear is ignored.
REQ-028 Reset mid-clear: assert reset at counter=1000 with 2 writes buffered -> clr_busy=0 and cpu_wr_ready=1 immediately; no further mem_we after reset release.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared widths, sizes and clear-engine state encoding for the VGA framebuffer arbiter.
package vga_fb_pkg;

    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FB_WORDS   = 307200;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous CPU write buffer with count-based full/empty flags.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA fetch > CPU write buffer > screen-clear engine.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = vga_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W     = vga_fb_pkg::DATA_W,
    parameter int unsigned FB_WORDS   = vga_fb_pkg::FB_WORDS,
    parameter int unsigned FIFO_DEPTH = vga_fb_pkg::FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import vga_fb_pkg::*;

    localparam int unsigned          WR_W     = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0]    CLR_LAST = ADDR_W'(FB_WORDS - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic [WR_W-1:0]   fifo_dout;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;

    logic              gnt_vga;
    logic              gnt_fifo;
    logic              gnt_clr;

    clr_state_t        clr_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;

    assign cpu_wr_ready           = !fifo_full;
    assign fifo_push              = cpu_wr_valid && !fifo_full;
    assign {fifo_addr, fifo_data} = fifo_dout;
    assign clr_busy               = (clr_state == CLEAR);
    assign vga_rd_data            = vga_rd_valid ? mem_rdata : '0;

    fb_wr_fifo #(
        .WIDTH (WR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({cpu_wr_addr, cpu_wr_data}),
        .pop       (gnt_fifo),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fixed-priority grant; held off while reset is asserted so the RAM port is idle at once.
    always_comb begin
        gnt_vga  = 1'b0;
        gnt_fifo = 1'b0;
        gnt_clr  = 1'b0;
        if (!reset) begin
            if (vga_rd_req) begin
                gnt_vga = 1'b1;
            end else if (!fifo_empty) begin
                gnt_fifo = 1'b1;
            end else if (clr_state == CLEAR) begin
                gnt_clr = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt_vga) begin
            mem_addr = vga_rd_addr;
        end else if (gnt_fifo) begin
            mem_addr  = fifo_addr;
            mem_we    = 1'b1;
            mem_wdata = fifo_data;
        end else if (gnt_clr) begin
            mem_addr  = clr_cnt;
            mem_we    = 1'b1;
            mem_wdata = clr_color_q;
        end
    end

    // RAM read data lands one cycle after the granted fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_rd_valid <= 1'b0;
        end else begin
            vga_rd_valid <= gnt_vga;
        end
    end

    // Clear engine: walks 0..FB_WORDS-1 only on cycles it wins the port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_state   <= IDLE;
            clr_cnt     <= '0;
            clr_color_q <= '0;
        end else begin
            case (clr_state)
                IDLE: begin
                    if (clr_start) begin
                        clr_state   <= CLEAR;
                        clr_cnt     <= '0;
                        clr_color_q <= clr_color;
                    end
                end
                CLEAR: begin
                    if (gnt_clr) begin
                        if (clr_cnt == CLR_LAST) begin
                            clr_state <= IDLE;
                            clr_cnt   <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: clr_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM; framebuffer shrunk to 2048 words.
module tb_vga_fb_arbiter;

    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FB_WORDS = 2048;

    logic              clock = 1'b0;
    logic              reset;
    logic              vga_rd_req;
    logic [ADDR_W-1:0] vga_rd_addr;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] ram [FB_WORDS];

    int n_vec = 0;
    int n_err = 0;

    vga_fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FB_WORDS   (FB_WORDS),
        .FIFO_DEPTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vga_rd_req   (vga_rd_req),
        .vga_rd_addr  (vga_rd_addr),
        .vga_rd_valid (vga_rd_valid),
        .vga_rd_data  (vga_rd_data),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .clr_busy     (clr_busy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM model (read-before-write).
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr[10:0]];
        if (mem_we) ram[mem_addr[10:0]] <= mem_wdata;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; vga_rd_req = 1'b1; vga_rd_addr = 19'h00055;
        #2;
        n_vec++; if (vga_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", vga_rd_valid); end
        n_vec++; if (vga_rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rdata got %0h want 0", vga_rd_data); end
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", clr_busy); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b want 0", mem_we); end
        n_vec++; if (mem_addr !== 19'h0) begin n_err++; $display("FAIL rst_addr got %0h want 0", mem_addr); end
        n_vec++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata got %0h want 0", mem_wdata); end
        n_vec++; if (cpu_wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", cpu_wr_ready); end
        step(); step();
        reset = 1'b0; vga_rd_req = 1'b0;
        @(negedge clock);
        n_vec++; if (vga_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid got %0b want 0", vga_rd_valid); end
    endtask

    task automatic test_read();
        step();
        vga_rd_req = 1'b1; vga_rd_addr = 19'h00010;
        @(negedge clock);
        n_vec++; if (mem_addr !== 19'h00010) begin n_err++; $display("FAIL rd_addr got %0h want 10", mem_addr); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_we got %0b want 0", mem_we); end
        step();
        vga_rd_req = 1'b0;
        @(negedge clock);
        n_vec++; if (vga_rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid got %0b want 1", vga_rd_valid); end
        n_vec++; if (vga_rd_data !== 8'h3C) begin n_err++; $display("FAIL rd_data got %0h want 3c", vga_rd_data); end
        step();
        @(negedge clock);
        n_vec++; if (vga_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_idle_valid got %0b want 0", vga_rd_valid); end
        n_vec++; if (vga_rd_data !== 8'h00) begin n_err++; $display("FAIL rd_idle_data got %0h want 0", vga_rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        step();
        for (int i = 0; i < 4; i++) begin
            vga_rd_req  = (i < 3);
            vga_rd_addr = ADDR_W'(i + 1);
            @(negedge clock);
            if (i > 0) begin
                n_vec++;
                if (vga_rd_valid !== 1'b1 || vga_rd_data !== exp[i-1]) begin
                    n_err++; $display("FAIL b2b_%0d got valid=%0b data=%0h want 1/%0h", i, vga_rd_valid, vga_rd_data, exp[i-1]);
                end
            end
            step();
        end
        vga_rd_req = 1'b0;
    endtask

    task automatic test_cpu_under_vga();
        int we_seen = 0;
        vga_rd_req = 1'b1; vga_rd_addr = 19'h00020;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 19'h00100; cpu_wr_data = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 0) begin
                n_vec++; if (cpu_wr_ready !== 1'b1) begin n_err++; $display("FAIL vga_load_ready got %0b want 1", cpu_wr_ready); end
            end
            if (mem_we !== 1'b0) we_seen++;
            step();
            cpu_wr_valid = 1'b0;
            if (i == 9) vga_rd_req = 1'b0;
        end
        n_vec++; if (we_seen != 0) begin n_err++; $display("FAIL vga_load_no_we got %0d writes want 0", we_seen); end
        @(negedge clock);
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 19'h00100 || mem_wdata !== 8'hAA) begin
            n_err++; $display("FAIL vga_load_drain got we=%0b addr=%0h data=%0h want 1/100/aa", mem_we, mem_addr, mem_wdata);
        end
        step();
    endtask

    task automatic test_push_pop();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 19'h00300; cpu_wr_data = 8'h11;
        @(negedge clock);
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL no_bypass got we=%0b want 0", mem_we); end
        step();
        cpu_wr_addr = 19'h00301; cpu_wr_data = 8'h22;
        @(negedge clock);
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 19'h00300 || mem_wdata !== 8'h11) begin
            n_err++; $display("FAIL pushpop_0 got we=%0b addr=%0h data=%0h want 1/300/11", mem_we, mem_addr, mem_wdata);
        end
        step();
        cpu_wr_valid = 1'b0;
        @(negedge clock);
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 19'h00301 || mem_wdata !== 8'h22) begin
            n_err++; $display("FAIL pushpop_1 got we=%0b addr=%0h data=%0h want 1/301/22", mem_we, mem_addr, mem_wdata);
        end
        step();
        @(negedge clock);
        n_vec++; if (mem_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin n_err++; $display("FAIL pushpop_empty got we=%0b ready=%0b want 0/1", mem_we, cpu_wr_ready); end
        step();
    endtask

    task automatic test_full();
        vga_rd_req = 1'b1; vga_rd_addr = 19'h0;
        for (int p = 0; p < 5; p++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = ADDR_W'(32'h200 + p); cpu_wr_data = DATA_W'(8'hA0 + p);
            @(negedge clock);
            n_vec++;
            if (cpu_wr_ready !== (p < 4)) begin
                n_err++; $display("FAIL full_push_%0d got ready=%0b want %0b", p, cpu_wr_ready, (p < 4));
            end
            step();
        end
        cpu_wr_valid = 1'b0; vga_rd_req = 1'b0;
        for (int q = 0; q < 5; q++) begin
            @(negedge clock);
            n_vec++;
            if (q < 4) begin
                if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(32'h200 + q) || mem_wdata !== DATA_W'(8'hA0 + q)
                    || cpu_wr_ready !== (q != 0)) begin
                    n_err++; $display("FAIL full_drain_%0d got we=%0b addr=%0h data=%0h ready=%0b want 1/%0h/%0h/%0b",
                                      q, mem_we, mem_addr, mem_wdata, cpu_wr_ready, 32'h200 + q, 8'hA0 + q, (q != 0));
                end
            end else if (mem_we !== 1'b0 || cpu_wr_ready !== 1'b1) begin
                n_err++; $display("FAIL full_done got we=%0b ready=%0b want 0/1", mem_we, cpu_wr_ready);
            end
            step();
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int bad = 0;
        clr_start = 1'b1; clr_color = 8'h07;
        @(negedge clock);
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL clr_start_busy got %0b want 0", clr_busy); end
        step();
        clr_start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!clr_busy) break;
            busy_cnt++;
            if (c == 0) begin
                n_vec++;
                if (mem_we !== 1'b1 || mem_addr !== 19'h0 || mem_wdata !== 8'h07) begin
                    n_err++; $display("FAIL clr_first got we=%0b addr=%0h data=%0h want 1/0/07", mem_we, mem_addr, mem_wdata);
                end
            end
            step();
            clr_start = (c == 99);
            clr_color = (c == 99) ? 8'h55 : 8'h07;
        end
        clr_start = 1'b0;
        n_vec++; if (busy_cnt != FB_WORDS) begin n_err++; $display("FAIL clr_busy_len got %0d want %0d", busy_cnt, FB_WORDS); end
        n_vec++; if (ram[0] !== 8'h07) begin n_err++; $display("FAIL clr_addr0 got %0h want 07", ram[0]); end
        n_vec++; if (ram[FB_WORDS-1] !== 8'h07) begin n_err++; $display("FAIL clr_addr_last got %0h want 07", ram[FB_WORDS-1]); end
        for (int a = 0; a < FB_WORDS; a++) if (ram[a] !== 8'h07) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL clr_all got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_mid_clear();
        int we_seen = 0;
        step();
        clr_start = 1'b1; clr_color = 8'h0F;
        step();
        clr_start = 1'b0;
        repeat (999) step();
        @(negedge clock);
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd999 || mem_wdata !== 8'h0F) begin
            n_err++; $display("FAIL mid_clr_addr got we=%0b addr=%0d data=%0h want 1/999/0f", mem_we, mem_addr, mem_wdata);
        end
        step();
        vga_rd_req = 1'b1; vga_rd_addr = 19'h00005;
        cpu_wr_valid = 1'b1; cpu_wr_addr = 19'h00010; cpu_wr_data = 8'h61;
        step();
        cpu_wr_addr = 19'h00011; cpu_wr_data = 8'h62;
        step();
        cpu_wr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %0b want 0", clr_busy); end
        n_vec++; if (cpu_wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %0b want 1", cpu_wr_ready); end
        n_vec++; if (vga_rd_valid !== 1'b0 || vga_rd_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_valid got %0b/%0h want 0/0", vga_rd_valid, vga_rd_data); end
        n_vec++; if (mem_we !== 1'b0 || mem_addr !== 19'h0) begin n_err++; $display("FAIL mid_rst_port got we=%0b addr=%0h want 0/0", mem_we, mem_addr); end
        step(); step();
        reset = 1'b0; vga_rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_we !== 1'b0) we_seen++;
            step();
        end
        n_vec++; if (we_seen != 0) begin n_err++; $display("FAIL post_rst_we got %0d writes want 0", we_seen); end
        n_vec++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy got %0b want 0", clr_busy); end
    endtask

    initial begin
        for (int a = 0; a < FB_WORDS; a++) ram[a] = '0;
        ram[16] = 8'h3C; ram[1] = 8'h11; ram[2] = 8'h22; ram[3] = 8'h33;
        reset = 1'b1; vga_rd_req = 1'b0; vga_rd_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        clr_start = 1'b0; clr_color = '0;
        test_reset();
        test_read();
        test_back_to_back();
        test_cpu_under_vga();
        test_push_pop();
        test_full();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
